spike_router_mc: RTL and testbench
==================================

// Module: spike_router_mc
// PURPOSE
//  Parametrised successor to the per-PE spike crossbar. Routes LANES-bit spike vectors between NUM_DIR
//  mesh ports and the local core, with multicast bypass and stateful integrate-and-fire (IF) spike generation.
//  Sits between the PE router adder tree and the core axon inputs, one instance per PE.
// PARAMETERS
//  NUM_DIR          4   mesh directions (index 0=N,1=S,2=E,3=W; more when >4)
//  LANES            4   spike bits per port per cycle
//  PS_WIDTH         13  local partial-sum width (signed)
//  ADDER_WIDTH      16  router adder-sum width (signed)
//  THRESHOLD_WIDTH  16  firing threshold width (signed)
//  POT_WIDTH        20  membrane potential width (signed, saturating)
//  RESET_MODE       0   0: potential cleared to 0 on fire; 1: threshold subtracted
// PORTS
//  clk_in          in   1                  clock
//  rstb            in   1                  reset, asynchronous, active-low
//  spike_sel       in   1                  block enable; 0 = every register holds
//  mode            in   2                  0 IDLE, 1 AXON, 2 BYPASS, 3 INJECT
//  in_sel          in   $clog2(NUM_DIR)    source direction for AXON/BYPASS
//  out_mask        in   NUM_DIR            multicast destination mask for BYPASS/INJECT
//  inject_lane     in   $clog2(LANES)      lane carrying the injected spike
//  spike_en        in   1                  integrate sum into potential this cycle
//  pot_clr         in   1                  synchronous potential clear (priority over spike_en)
//  sum_or_local    in   1                  0: sign-extended local_ps, 1: adder_sum
//  local_ps        in   PS_WIDTH           local neuron partial sum
//  adder_sum       in   ADDER_WIDTH        router adder output
//  threshold       in   THRESHOLD_WIDTH    firing threshold
//  spike_in        in   NUM_DIR*LANES      incoming spikes, direction d at [d*LANES +: LANES]
//  spike_out       out  NUM_DIR*LANES      outgoing spikes, same packing, registered
//  spike_out_core  out  LANES              axon spikes to core, registered
//  core_vld        out  1                  spike_out_core valid pulse
//  fire            out  1                  registered fire flag of the IF neuron
//  pot             out  POT_WIDTH          current membrane potential (observe)
//  err_uturn       out  1                  sticky: out_mask included in_sel during BYPASS
// BEHAVIOUR
//  - Reset (rstb=0, async): all registers incl. every output, pot, fire, err_uturn -> 0.
//  - spike_sel=0: all state and outputs hold (gated-clock equivalence); no pulse clearing.
//  - Pulse semantics: with spike_sel=1, spike_out, spike_out_core, core_vld default to 0 each cycle
//    unless driven below; spikes never persist beyond one cycle.
//  - Input regs in_reg[d]: load spike_in[d] only in mode AXON; hold otherwise.
//  - AXON: spike_out_core <= in_reg[in_sel], core_vld <= 1; pin-to-core latency 2 cycles.
//  - BYPASS: for each d with out_mask[d]=1 and d!=in_sel: spike_out[d] <= spike_in[in_sel]; latency 1.
//    out_mask[in_sel]=1 -> that port suppressed (no U-turn), err_uturn <= 1 (cleared only by reset).
//  - INJECT: for each d with out_mask[d]=1: spike_out[d][inject_lane] <= fire, other lanes 0.
//    Injection uses registered fire, so INJECT is issued the cycle after spike_en.
//  - IDLE: only neuron updates; routing outputs 0.
//  - Neuron: sum = sum_or_local ? adder_sum : sext(local_ps) to ADDER_WIDTH; sext to POT_WIDTH.
//    pot_clr: pot<=0, fire<=0. Else spike_en: p = sat(pot+sum) to [-2^(POT_WIDTH-1), 2^(POT_WIDTH-1)-1];
//    p >= sext(threshold) -> fire<=1, pot <= RESET_MODE ? p-threshold : 0; else fire<=0, pot<=p.
//    spike_en=0: pot holds, fire<=0. Neuron runs independent of mode (may integrate during BYPASS).
//  - Mode change mid-stream takes effect next edge; in_reg contents retained across non-AXON modes.
// STRUCTURE
//  - spike_pkg: mode_e enum, DIR_N/S/E/W localparams, sext/sat functions.
//  - Sub-module spike_if_neuron (potential, saturation, threshold compare, reset mode); router logic
//    (input regs, mux, multicast, pulse outputs, err_uturn) stays in spike_router_mc.
// TESTING
//  - Reset mid-BYPASS: drop rstb async between edges -> all outputs 0 immediately, pot=0.
//  - AXON: spike_in E=4'b1010, in_sel=2 at cycle 0 -> spike_out_core=4'b1010, core_vld=1 at cycle 2 only.
//  - BYPASS multicast: in_sel=0, out_mask=4'b1110, N=4'b0110 -> S,E,W=4'b0110 next cycle; mask 4'b0011 -> S only, err_uturn=1.
//  - IF: threshold=100, local_ps=40 x3 spike_en -> pot 40,80,0 and fire=1 on 3rd; RESET_MODE=1 -> pot=20.
//  - Inject: fire=1, mode=INJECT, out_mask=4'b0100, inject_lane=3 -> spike_out E=4'b1000, others 0.
//  - Saturation/sign: local_ps=13'h1000 (-4096), repeated to pot min -> pot holds at -2^19, fire=0; spike_sel=0 freezes all.

Source files
------------

// File: rtl/spike_pkg.sv
// -----------------------------------------------------------------------------
// spike_pkg
// Shared types and helpers for the multicast spike router and its IF neuron.
//   mode_e      : routing mode carried on the 2-bit 'mode' port
//   DIR_*       : mesh direction indices used to pack spike vectors
//   sext / sat  : width-generic sign extension and saturation on 64-bit values,
//                 so parametrised modules can share one implementation
// -----------------------------------------------------------------------------
package spike_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_AXON   = 2'd1,
        MODE_BYPASS = 2'd2,
        MODE_INJECT = 2'd3
    } mode_e;

    localparam int DIR_N = 0;
    localparam int DIR_S = 1;
    localparam int DIR_E = 2;
    localparam int DIR_W = 3;

    // Treat the low 'width' bits of value as a two's-complement number and
    // sign-extend it to 64 bits; any bits above 'width' are discarded.
    function automatic logic signed [63:0] sext(input logic [63:0] value,
                                                input int unsigned width);
        logic [63:0] shifted;
        shifted = value << (64 - width);
        return $signed(shifted) >>> (64 - width);
    endfunction

    // Clamp a 64-bit signed value into the range of a 'width'-bit signed number.
    function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                               input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/spike_if_neuron.sv
// -----------------------------------------------------------------------------
// spike_if_neuron
// Integrate-and-fire neuron with a saturating membrane potential.
//   clk_in, rstb    : clock, asynchronous active-low reset
//   enable          : block enable; when low the potential and fire flag hold
//   spike_en        : integrate the selected sum this cycle
//   pot_clr         : synchronous clear of potential and fire (wins over spike_en)
//   sum_or_local    : 0 selects sign-extended local_ps, 1 selects adder_sum
//   local_ps        : local partial sum (signed, PS_WIDTH)
//   adder_sum       : router adder sum (signed, ADDER_WIDTH)
//   threshold       : firing threshold (signed, THRESHOLD_WIDTH)
//   fire            : registered fire flag, high for one enabled cycle per fire
//   pot             : membrane potential (signed, POT_WIDTH)
// -----------------------------------------------------------------------------
module spike_if_neuron
    import spike_pkg::*;
#(
    parameter int PS_WIDTH        = 13,
    parameter int ADDER_WIDTH     = 16,
    parameter int THRESHOLD_WIDTH = 16,
    parameter int POT_WIDTH       = 20,
    parameter int RESET_MODE      = 0
) (
    input  logic                       clk_in,
    input  logic                       rstb,
    input  logic                       enable,
    input  logic                       spike_en,
    input  logic                       pot_clr,
    input  logic                       sum_or_local,
    input  logic [PS_WIDTH-1:0]        local_ps,
    input  logic [ADDER_WIDTH-1:0]     adder_sum,
    input  logic [THRESHOLD_WIDTH-1:0] threshold,
    output logic                       fire,
    output logic [POT_WIDTH-1:0]       pot
);

    logic signed [63:0]   sum_adder;
    logic signed [63:0]   sum_pot;
    logic signed [63:0]   thr_ext;
    logic signed [63:0]   pot_ext;
    logic signed [63:0]   acc;
    logic [POT_WIDTH-1:0] pot_next;
    logic                 fire_next;

    always_comb begin
        // The local sum is first brought to the adder width so both sources
        // wrap identically before being widened to the potential.
        if (sum_or_local) begin
            sum_adder = sext(64'(adder_sum), ADDER_WIDTH);
        end else begin
            sum_adder = sext(sext(64'(local_ps), PS_WIDTH), ADDER_WIDTH);
        end
        sum_pot = sext(sum_adder, POT_WIDTH);
        thr_ext = sext(64'(threshold), THRESHOLD_WIDTH);
        pot_ext = sext(64'(pot), POT_WIDTH);
        acc     = sat(pot_ext + sum_pot, POT_WIDTH);

        pot_next  = pot;
        fire_next = 1'b0;
        if (pot_clr) begin
            pot_next = '0;
        end else if (spike_en) begin
            if (acc >= thr_ext) begin
                fire_next = 1'b1;
                // Subtract mode saturates too: a negative threshold could
                // otherwise push the leftover past the positive limit.
                if (RESET_MODE != 0) begin
                    pot_next = POT_WIDTH'(sat(acc - thr_ext, POT_WIDTH));
                end else begin
                    pot_next = '0;
                end
            end else begin
                pot_next = acc[POT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rstb) begin
        if (!rstb) begin
            pot  <= '0;
            fire <= 1'b0;
        end else if (enable) begin
            pot  <= pot_next;
            fire <= fire_next;
        end
    end

endmodule

// File: rtl/spike_router_mc.sv
// -----------------------------------------------------------------------------
// spike_router_mc
// Per-PE spike router: moves LANES-bit spike vectors between NUM_DIR mesh ports
// and the local core, with multicast bypass and spike injection from an
// integrate-and-fire neuron.
//   clk_in, rstb    : clock, asynchronous active-low reset
//   spike_sel       : block enable; when low every register holds
//   mode            : IDLE / AXON / BYPASS / INJECT (see spike_pkg::mode_e)
//   in_sel          : source direction for AXON and BYPASS
//   out_mask        : multicast destination mask for BYPASS and INJECT
//   inject_lane     : lane that carries the injected fire bit
//   spike_en, pot_clr, sum_or_local, local_ps, adder_sum, threshold
//                   : neuron controls and operands
//   spike_in        : incoming spikes, direction d at [d*LANES +: LANES]
//   spike_out       : registered outgoing spikes, same packing, one-cycle pulses
//   spike_out_core  : registered axon spikes to the core
//   core_vld        : one-cycle valid for spike_out_core
//   fire, pot       : neuron fire flag and membrane potential
//   err_uturn       : sticky flag, BYPASS mask pointed back at its source
// -----------------------------------------------------------------------------
module spike_router_mc
    import spike_pkg::*;
#(
    parameter  int NUM_DIR         = 4,
    parameter  int LANES           = 4,
    parameter  int PS_WIDTH        = 13,
    parameter  int ADDER_WIDTH     = 16,
    parameter  int THRESHOLD_WIDTH = 16,
    parameter  int POT_WIDTH       = 20,
    parameter  int RESET_MODE      = 0,
    localparam int SEL_WIDTH       = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1,
    localparam int LANE_WIDTH      = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                       clk_in,
    input  logic                       rstb,
    input  logic                       spike_sel,
    input  logic [1:0]                 mode,
    input  logic [SEL_WIDTH-1:0]       in_sel,
    input  logic [NUM_DIR-1:0]         out_mask,
    input  logic [LANE_WIDTH-1:0]      inject_lane,
    input  logic                       spike_en,
    input  logic                       pot_clr,
    input  logic                       sum_or_local,
    input  logic [PS_WIDTH-1:0]        local_ps,
    input  logic [ADDER_WIDTH-1:0]     adder_sum,
    input  logic [THRESHOLD_WIDTH-1:0] threshold,
    input  logic [NUM_DIR*LANES-1:0]   spike_in,
    output logic [NUM_DIR*LANES-1:0]   spike_out,
    output logic [LANES-1:0]           spike_out_core,
    output logic                       core_vld,
    output logic                       fire,
    output logic [POT_WIDTH-1:0]       pot,
    output logic                       err_uturn
);

    mode_e                    cur_mode;
    logic [LANES-1:0]         in_reg [NUM_DIR];
    logic [LANES-1:0]         src_bits;
    logic [NUM_DIR*LANES-1:0] out_next;
    logic [LANES-1:0]         core_next;
    logic                     vld_next;
    logic                     err_next;

    assign cur_mode = mode_e'(mode);
    assign src_bits = spike_in[in_sel*LANES +: LANES];

    // Next-cycle routing outputs. Everything defaults to zero so spikes are
    // single-cycle pulses; only err_uturn carries over.
    always_comb begin
        out_next  = '0;
        core_next = '0;
        vld_next  = 1'b0;
        err_next  = err_uturn;
        case (cur_mode)
            MODE_AXON: begin
                core_next = in_reg[in_sel];
                vld_next  = 1'b1;
            end
            MODE_BYPASS: begin
                // A spike is never sent back out of the port it arrived on.
                for (int d = 0; d < NUM_DIR; d++) begin
                    if (out_mask[d] && (SEL_WIDTH'(d) != in_sel)) begin
                        out_next[d*LANES +: LANES] = src_bits;
                    end
                end
                if (out_mask[in_sel]) begin
                    err_next = 1'b1;
                end
            end
            MODE_INJECT: begin
                // Out-of-range lanes are dropped rather than spilling into
                // the neighbouring direction's field.
                for (int d = 0; d < NUM_DIR; d++) begin
                    if (out_mask[d] && (int'(inject_lane) < LANES)) begin
                        out_next[d*LANES + int'(inject_lane)] = fire;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Input registers only capture in AXON so the core can be fed from a
    // stable copy while the mesh inputs keep changing in other modes.
    always_ff @(posedge clk_in or negedge rstb) begin
        if (!rstb) begin
            for (int d = 0; d < NUM_DIR; d++) begin
                in_reg[d] <= '0;
            end
        end else if (spike_sel && (cur_mode == MODE_AXON)) begin
            for (int d = 0; d < NUM_DIR; d++) begin
                in_reg[d] <= spike_in[d*LANES +: LANES];
            end
        end
    end

    // Registered routing outputs; spike_sel low freezes them like a gated clock.
    always_ff @(posedge clk_in or negedge rstb) begin
        if (!rstb) begin
            spike_out      <= '0;
            spike_out_core <= '0;
            core_vld       <= 1'b0;
            err_uturn      <= 1'b0;
        end else if (spike_sel) begin
            spike_out      <= out_next;
            spike_out_core <= core_next;
            core_vld       <= vld_next;
            err_uturn      <= err_next;
        end
    end

    spike_if_neuron #(
        .PS_WIDTH        (PS_WIDTH),
        .ADDER_WIDTH     (ADDER_WIDTH),
        .THRESHOLD_WIDTH (THRESHOLD_WIDTH),
        .POT_WIDTH       (POT_WIDTH),
        .RESET_MODE      (RESET_MODE)
    ) u_neuron (
        .clk_in       (clk_in),
        .rstb         (rstb),
        .enable       (spike_sel),
        .spike_en     (spike_en),
        .pot_clr      (pot_clr),
        .sum_or_local (sum_or_local),
        .local_ps     (local_ps),
        .adder_sum    (adder_sum),
        .threshold    (threshold),
        .fire         (fire),
        .pot          (pot)
    );

endmodule

// File: tb/tb_spike_router_mc.sv
// -----------------------------------------------------------------------------
// tb_spike_router_mc
// Drives two routers (clear-on-fire and subtract-on-fire) with the same inputs
// and compares both against a cycle-level behavioural model, plus directed
// checks for AXON latency, BYPASS multicast/U-turn, IF firing, injection,
// saturation, enable freeze and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_spike_router_mc;

    localparam int NUM_DIR = 4;
    localparam int LANES   = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] AXON   = 2'd1;
    localparam logic [1:0] BYPASS = 2'd2;
    localparam logic [1:0] INJECT = 2'd3;

    logic        clk_in = 1'b0;
    logic        rstb;
    logic        spike_sel;
    logic [1:0]  mode;
    logic [1:0]  in_sel;
    logic [3:0]  out_mask;
    logic [1:0]  inject_lane;
    logic        spike_en;
    logic        pot_clr;
    logic        sum_or_local;
    logic [12:0] local_ps;
    logic [15:0] adder_sum;
    logic [15:0] threshold;
    logic [15:0] spike_in;

    logic [15:0] spike_out0, spike_out1;
    logic [3:0]  core0, core1;
    logic        vld0, vld1, fire0, fire1, err0, err1;
    logic [19:0] pot0, pot1;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state; index k selects reset mode (0 clear, 1 subtract).
    logic [3:0]  m_in [NUM_DIR];
    logic [15:0] m_out [2];
    logic [3:0]  m_core;
    bit          m_vld;
    bit          m_err;
    longint      m_pot [2];
    bit          m_fire [2];

    always #5 clk_in = ~clk_in;

    spike_router_mc #(.RESET_MODE(0)) dut (
        .clk_in(clk_in), .rstb(rstb), .spike_sel(spike_sel), .mode(mode),
        .in_sel(in_sel), .out_mask(out_mask), .inject_lane(inject_lane),
        .spike_en(spike_en), .pot_clr(pot_clr), .sum_or_local(sum_or_local),
        .local_ps(local_ps), .adder_sum(adder_sum), .threshold(threshold),
        .spike_in(spike_in), .spike_out(spike_out0), .spike_out_core(core0),
        .core_vld(vld0), .fire(fire0), .pot(pot0), .err_uturn(err0)
    );

    spike_router_mc #(.RESET_MODE(1)) dut_rm1 (
        .clk_in(clk_in), .rstb(rstb), .spike_sel(spike_sel), .mode(mode),
        .in_sel(in_sel), .out_mask(out_mask), .inject_lane(inject_lane),
        .spike_en(spike_en), .pot_clr(pot_clr), .sum_or_local(sum_or_local),
        .local_ps(local_ps), .adder_sum(adder_sum), .threshold(threshold),
        .spike_in(spike_in), .spike_out(spike_out1), .spike_out_core(core1),
        .core_vld(vld1), .fire(fire1), .pot(pot1), .err_uturn(err1)
    );

    // Interpret the low w bits of v as a two's-complement number.
    function automatic longint toSigned(input longint v, input int w);
        longint m;
        m = longint'(1) << w;
        v = v & (m - 1);
        return (v >= (m >> 1)) ? v - m : v;
    endfunction

    function automatic longint clampPot(input longint v);
        if (v > 524287) return 524287;
        if (v < -524288) return -524288;
        return v;
    endfunction

    task automatic modelReset();
        for (int d = 0; d < NUM_DIR; d++) m_in[d] = '0;
        for (int k = 0; k < 2; k++) begin
            m_out[k]  = '0;
            m_pot[k]  = 0;
            m_fire[k] = 0;
        end
        m_core = '0;
        m_vld  = 0;
        m_err  = 0;
    endtask

    // One clock edge of the model, using the inputs as currently driven.
    task automatic modelStep();
        longint     sum;
        longint     thr;
        longint     p;
        logic [3:0] src;
        logic [15:0] nxt [2];
        if (spike_sel) begin
            nxt[0] = '0;
            nxt[1] = '0;
            m_core = '0;
            m_vld  = 0;
            case (mode)
                AXON: begin
                    m_core = m_in[in_sel];
                    m_vld  = 1;
                    for (int d = 0; d < NUM_DIR; d++) m_in[d] = spike_in[4*d +: 4];
                end
                BYPASS: begin
                    src = spike_in[4*in_sel +: 4];
                    for (int d = 0; d < NUM_DIR; d++)
                        if (out_mask[d] && d != int'(in_sel))
                            for (int k = 0; k < 2; k++) nxt[k][4*d +: 4] = src;
                    if (out_mask[in_sel]) m_err = 1;
                end
                INJECT: begin
                    for (int d = 0; d < NUM_DIR; d++)
                        if (out_mask[d])
                            for (int k = 0; k < 2; k++) nxt[k][4*d + int'(inject_lane)] = m_fire[k];
                end
                default: begin
                end
            endcase
            m_out[0] = nxt[0];
            m_out[1] = nxt[1];

            sum = sum_or_local ? toSigned(longint'(adder_sum), 16) : toSigned(longint'(local_ps), 13);
            thr = toSigned(longint'(threshold), 16);
            for (int k = 0; k < 2; k++) begin
                if (pot_clr) begin
                    m_pot[k]  = 0;
                    m_fire[k] = 0;
                end else if (spike_en) begin
                    p = clampPot(m_pot[k] + sum);
                    if (p >= thr) begin
                        m_fire[k] = 1;
                        m_pot[k]  = (k == 1) ? clampPot(p - thr) : 0;
                    end else begin
                        m_fire[k] = 0;
                        m_pot[k]  = p;
                    end
                end else begin
                    m_fire[k] = 0;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        logic [19:0] e0;
        logic [19:0] e1;
        e0 = m_pot[0][19:0];
        e1 = m_pot[1][19:0];
        checkOutput("spike_out",      32'(spike_out0), 32'(m_out[0]));
        checkOutput("spike_out_rm1",  32'(spike_out1), 32'(m_out[1]));
        checkOutput("spike_out_core", 32'(core0),      32'(m_core));
        checkOutput("core_rm1",       32'(core1),      32'(m_core));
        checkOutput("core_vld",       32'(vld0),       32'(m_vld));
        checkOutput("core_vld_rm1",   32'(vld1),       32'(m_vld));
        checkOutput("err_uturn",      32'(err0),       32'(m_err));
        checkOutput("err_uturn_rm1",  32'(err1),       32'(m_err));
        checkOutput("fire",           32'(fire0),      32'(m_fire[0]));
        checkOutput("fire_rm1",       32'(fire1),      32'(m_fire[1]));
        checkOutput("pot",            32'(pot0),       32'(e0));
        checkOutput("pot_rm1",        32'(pot1),       32'(e1));
    endtask

    // Clock one edge with the currently driven inputs, then compare.
    task automatic applyStimulus();
        @(posedge clk_in);
        modelStep();
        #2;
        checkAll();
    endtask

    initial begin
        rstb = 1'b0; spike_sel = 1'b1; mode = IDLE; in_sel = '0; out_mask = '0;
        inject_lane = '0; spike_en = 1'b0; pot_clr = 1'b0; sum_or_local = 1'b0;
        local_ps = '0; adder_sum = '0; threshold = '0; spike_in = '0;
        modelReset();
        repeat (2) @(posedge clk_in);
        #2;
        checkAll();
        rstb = 1'b1;

        $display("[TB] AXON latency");
        mode = AXON; in_sel = 2'd2; spike_in = 16'h0A00;
        applyStimulus();
        checkOutput("axon_c1_core", 32'(core0), 32'h0);
        spike_in = 16'h0000;
        applyStimulus();
        checkOutput("axon_c2_core", 32'(core0), 32'hA);
        checkOutput("axon_c2_vld",  32'(vld0),  32'h1);
        mode = IDLE;
        applyStimulus();
        checkOutput("axon_c3_vld",  32'(vld0),  32'h0);

        $display("[TB] BYPASS multicast");
        mode = BYPASS; in_sel = 2'd0; out_mask = 4'b1110; spike_in = 16'h0006;
        applyStimulus();
        checkOutput("bypass_multicast", 32'(spike_out0), 32'h6660);
        checkOutput("bypass_no_err",    32'(err0),       32'h0);
        out_mask = 4'b0011;
        applyStimulus();
        checkOutput("bypass_uturn_out", 32'(spike_out0), 32'h0060);
        checkOutput("bypass_uturn_err", 32'(err0),       32'h1);
        mode = IDLE; out_mask = 4'b0000;
        applyStimulus();
        checkOutput("idle_out_zero",    32'(spike_out0), 32'h0);
        checkOutput("err_sticky",       32'(err0),       32'h1);

        $display("[TB] integrate and fire");
        threshold = 16'd100; local_ps = 13'd40; sum_or_local = 1'b0; spike_en = 1'b1;
        applyStimulus();
        checkOutput("if_pot_40", 32'(pot0), 32'd40);
        applyStimulus();
        checkOutput("if_pot_80", 32'(pot0), 32'd80);
        applyStimulus();
        checkOutput("if_fire",         32'(fire0), 32'h1);
        checkOutput("if_pot_cleared",  32'(pot0),  32'd0);
        checkOutput("if_pot_subtract", 32'(pot1),  32'd20);

        $display("[TB] inject");
        spike_en = 1'b0; mode = INJECT; out_mask = 4'b0100; inject_lane = 2'd3;
        applyStimulus();
        checkOutput("inject_out",     32'(spike_out0), 32'h0800);
        checkOutput("inject_fire_lo", 32'(fire0),      32'h0);

        $display("[TB] negative saturation");
        mode = IDLE; out_mask = 4'b0000; pot_clr = 1'b1;
        applyStimulus();
        pot_clr = 1'b0; local_ps = 13'h1000; spike_en = 1'b1;
        repeat (130) applyStimulus();
        checkOutput("sat_pot_min",     32'(pot0),  32'h80000);
        checkOutput("sat_pot_min_rm1", 32'(pot1),  32'h80000);
        checkOutput("sat_no_fire",     32'(fire0), 32'h0);

        $display("[TB] enable freeze");
        mode = BYPASS; in_sel = 2'd1; out_mask = 4'b0001; spike_in = 16'h00F0;
        applyStimulus();
        checkOutput("freeze_pre_out", 32'(spike_out0), 32'h000F);
        spike_sel = 1'b0; mode = AXON; local_ps = 13'd40; spike_in = 16'hFFFF;
        repeat (3) applyStimulus();
        checkOutput("freeze_out", 32'(spike_out0), 32'h000F);
        checkOutput("freeze_pot", 32'(pot0),       32'h80000);
        checkOutput("freeze_vld", 32'(vld0),       32'h0);

        $display("[TB] async reset mid-BYPASS");
        spike_sel = 1'b1; mode = BYPASS; in_sel = 2'd0; out_mask = 4'b1110;
        spike_in = 16'h0005; spike_en = 1'b0;
        applyStimulus();
        checkOutput("pre_reset_out", 32'(spike_out0), 32'h5550);
        rstb = 1'b0;
        #1;
        checkOutput("rst_out",  32'(spike_out0), 32'h0);
        checkOutput("rst_pot",  32'(pot0),       32'h0);
        checkOutput("rst_pot1", 32'(pot1),       32'h0);
        checkOutput("rst_err",  32'(err0),       32'h0);
        checkOutput("rst_core", 32'(core0),      32'h0);
        checkOutput("rst_fire", 32'(fire0),      32'h0);
        modelReset();
        #1;
        rstb = 1'b1;

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            spike_sel    = ($urandom_range(0, 9) != 0);
            mode         = 2'($urandom_range(0, 3));
            in_sel       = 2'($urandom_range(0, 3));
            out_mask     = 4'($urandom);
            inject_lane  = 2'($urandom_range(0, 3));
            spike_en     = ($urandom_range(0, 9) < 7);
            pot_clr      = ($urandom_range(0, 19) == 0);
            sum_or_local = ($urandom_range(0, 3) == 0);
            local_ps     = 13'($urandom);
            adder_sum    = 16'($urandom);
            threshold    = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 3000)) : 16'($urandom);
            spike_in     = 16'($urandom);
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
